// File: rtl/bram_demux_pkg.sv
// rtl/bram_demux_pkg.sv - shared types, constants and helpers for the BRAM port demux
package bram_demux_pkg;

    localparam int          STAT_W           = 16;
    localparam int          SEL_MAX_W        = 4;
    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hABADC0DE;

    typedef struct packed {
        logic                 valid;
        logic                 oor;
        logic [SEL_MAX_W-1:0] idx;
    } sel_stage_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/bram_demux_sel_pipe.sv
// rtl/bram_demux_sel_pipe.sv - read-select delay line matched to BRAM latency, with held output
module bram_demux_sel_pipe
    import bram_demux_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 oor,
    input  logic [SEL_MAX_W-1:0] idx,
    output logic                 sel_oor,
    output logic [SEL_MAX_W-1:0] sel_idx
);

    sel_stage_t           stage [READ_LATENCY];
    logic                 held_oor;
    logic [SEL_MAX_W-1:0] held_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) stage[i] <= '0;
            held_oor <= 1'b0;
            held_idx <= '0;
        end else begin
            stage[0] <= {ena, oor, idx};
            for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
            if (stage[READ_LATENCY-1].valid) begin
                held_oor <= stage[READ_LATENCY-1].oor;
                held_idx <= stage[READ_LATENCY-1].idx;
            end
        end
    end

    // Between reads the mux keeps pointing at the last region read so rdata stays stable.
    assign sel_oor = stage[READ_LATENCY-1].valid ? stage[READ_LATENCY-1].oor : held_oor;
    assign sel_idx = stage[READ_LATENCY-1].valid ? stage[READ_LATENCY-1].idx : held_idx;

endmodule

// File: rtl/bram_port_demux_n.sv
// rtl/bram_port_demux_n.sv - N-way BRAM port demux with out-of-range logging; BRAM_PORT_DEMUX_STATS_EN adds per-port write counters
module bram_port_demux_n
    import bram_demux_pkg::*;
#(
    parameter int                N_PORTS      = 5,
    parameter int                REGION_AW    = 12,
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] ERR_WORD     = ERR_WORD_DEFAULT
) (
    input  logic                          bram_in_clk,
    input  logic                          bram_in_rst_n,
    input  logic                          bram_in_rst,
    input  logic                          bram_in_ena,
    input  logic [DATA_W/8-1:0]           bram_in_we,
    input  logic [ADDR_W-1:0]             bram_in_addr,
    input  logic [DATA_W-1:0]             bram_in_wdata,
    output logic [DATA_W-1:0]             bram_in_rdata,
    output logic [N_PORTS-1:0]            bram_out_clk,
    output logic [N_PORTS-1:0]            bram_out_rst,
    output logic [N_PORTS-1:0]            bram_out_ena,
    output logic [N_PORTS*DATA_W/8-1:0]   bram_out_we,
    output logic [N_PORTS*ADDR_W-1:0]     bram_out_addr,
    output logic [N_PORTS*DATA_W-1:0]     bram_out_wdata,
    input  logic [N_PORTS*DATA_W-1:0]     bram_out_rdata,
    input  logic                          err_clr,
    output logic                          err_sticky,
    output logic [ADDR_W-1:0]             err_addr,
    output logic [STAT_W-1:0]             err_count,
    output logic [N_PORTS*STAT_W-1:0]     stat_wr_cnt
);

    localparam int              SEL_W   = clog2_min1(N_PORTS);
    localparam logic [STAT_W-1:0] CNT_MAX = '1;

    logic [SEL_W-1:0]     idx;
    logic [SEL_MAX_W-1:0] idx_w;
    logic                 oor;
    logic                 err_hit;
    logic                 sel_oor;
    logic [SEL_MAX_W-1:0] sel_idx;

    assign idx     = bram_in_addr[REGION_AW +: SEL_W];
    assign idx_w   = SEL_MAX_W'(idx);
    // One extra bit so N_PORTS = 16 does not wrap to zero in the compare.
    assign oor     = ({1'b0, idx_w} >= (SEL_MAX_W+1)'(N_PORTS));
    assign err_hit = bram_in_ena & oor;

    assign bram_out_clk   = {N_PORTS{bram_in_clk}};
    assign bram_out_rst   = {N_PORTS{bram_in_rst}};
    assign bram_out_we    = {N_PORTS{bram_in_we}};
    assign bram_out_addr  = {N_PORTS{bram_in_addr}};
    assign bram_out_wdata = {N_PORTS{bram_in_wdata}};

    always_comb begin
        bram_out_ena = '0;
        for (int k = 0; k < N_PORTS; k++)
            bram_out_ena[k] = bram_in_ena && (idx_w == SEL_MAX_W'(k));
    end

    bram_demux_sel_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_sel_pipe (
        .clk     (bram_in_clk),
        .rst_n   (bram_in_rst_n),
        .ena     (bram_in_ena),
        .oor     (oor),
        .idx     (idx_w),
        .sel_oor (sel_oor),
        .sel_idx (sel_idx)
    );

    always_comb begin
        bram_in_rdata = '0;
        for (int k = 0; k < N_PORTS; k++)
            if (sel_idx == SEL_MAX_W'(k)) bram_in_rdata = bram_out_rdata[k*DATA_W +: DATA_W];
        if (sel_oor) bram_in_rdata = ERR_WORD;
    end

    // An error arriving with a clear is logged as the first event after the clear.
    always_ff @(posedge bram_in_clk or negedge bram_in_rst_n) begin
        if (!bram_in_rst_n) begin
            err_sticky <= 1'b0;
            err_addr   <= '0;
            err_count  <= '0;
        end else if (err_hit) begin
            err_sticky <= 1'b1;
            if (!err_sticky || err_clr) err_addr <= bram_in_addr;
            if (err_clr)                err_count <= STAT_W'(1);
            else if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_addr   <= '0;
            err_count  <= '0;
        end
    end

`ifdef BRAM_PORT_DEMUX_STATS_EN
    logic [STAT_W-1:0] wr_cnt [N_PORTS];

    always_ff @(posedge bram_in_clk or negedge bram_in_rst_n) begin
        if (!bram_in_rst_n) begin
            for (int k = 0; k < N_PORTS; k++) wr_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (err_clr)
                    wr_cnt[k] <= '0;
                else if (bram_out_ena[k] && (|bram_in_we) && (wr_cnt[k] != CNT_MAX))
                    wr_cnt[k] <= wr_cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_wr_cnt = '0;
        for (int k = 0; k < N_PORTS; k++) stat_wr_cnt[k*STAT_W +: STAT_W] = wr_cnt[k];
    end
`else
    assign stat_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_port_demux_n.sv
// tb/tb_bram_port_demux_n.sv - scoreboard bench for bram_port_demux_n (N_PORTS=5, READ_LATENCY=2)
module tb_bram_port_demux_n;

    localparam int NP = 5;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [31:0] ERR = 32'hABADC0DE;

    logic              clk;
    logic              rst_n;
    logic              bram_in_rst;
    logic              bram_in_ena;
    logic [3:0]        bram_in_we;
    logic [AW-1:0]     bram_in_addr;
    logic [DW-1:0]     bram_in_wdata;
    logic [DW-1:0]     bram_in_rdata;
    logic [NP-1:0]     bram_out_clk;
    logic [NP-1:0]     bram_out_rst;
    logic [NP-1:0]     bram_out_ena;
    logic [NP*4-1:0]   bram_out_we;
    logic [NP*AW-1:0]  bram_out_addr;
    logic [NP*DW-1:0]  bram_out_wdata;
    logic [NP*DW-1:0]  bram_out_rdata;
    logic              err_clr;
    logic              err_sticky;
    logic [AW-1:0]     err_addr;
    logic [15:0]       err_count;
    logic [NP*16-1:0]  stat_wr_cnt;

    bram_port_demux_n #(
        .N_PORTS      (NP),
        .REGION_AW    (12),
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .READ_LATENCY (2),
        .ERR_WORD     (ERR)
    ) dut (
        .bram_in_clk    (clk),
        .bram_in_rst_n  (rst_n),
        .bram_in_rst    (bram_in_rst),
        .bram_in_ena    (bram_in_ena),
        .bram_in_we     (bram_in_we),
        .bram_in_addr   (bram_in_addr),
        .bram_in_wdata  (bram_in_wdata),
        .bram_in_rdata  (bram_in_rdata),
        .bram_out_clk   (bram_out_clk),
        .bram_out_rst   (bram_out_rst),
        .bram_out_ena   (bram_out_ena),
        .bram_out_we    (bram_out_we),
        .bram_out_addr  (bram_out_addr),
        .bram_out_wdata (bram_out_wdata),
        .bram_out_rdata (bram_out_rdata),
        .err_clr        (err_clr),
        .err_sticky     (err_sticky),
        .err_addr       (err_addr),
        .err_count      (err_count),
        .stat_wr_cnt    (stat_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-2 BRAM per port, read-first
    logic [31:0] mem [NP][16];
    logic [31:0] r1 [NP];
    logic [31:0] r2 [NP];

    always @(posedge clk) begin
        for (int k = 0; k < NP; k++) begin
            if (bram_out_ena[k]) begin
                for (int b = 0; b < 4; b++)
                    if (bram_out_we[k*4+b])
                        mem[k][bram_out_addr[k*AW+2 +: 4]][b*8 +: 8] <= bram_out_wdata[k*DW+b*8 +: 8];
                r1[k] <= mem[k][bram_out_addr[k*AW+2 +: 4]];
            end
            r2[k] <= r1[k];
        end
    end

    always_comb begin
        bram_out_rdata = '0;
        for (int k = 0; k < NP; k++) bram_out_rdata[k*DW +: DW] = r2[k];
    end

    typedef struct {
        int          due;
        logic [31:0] data;
        string       tag;
    } sb_t;

    sb_t         sbq [$];
    logic [31:0] shadow [NP][16];
    int          cyc;
    int          n_vec;
    int          n_miss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due < cyc) check({"late_", e.tag}, 64'(cyc), 64'(e.due));
            else             check(e.tag, 64'(bram_in_rdata), 64'(e.data));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            bram_in_ena = 1'b0;
            bram_in_we  = '0;
            err_clr     = 1'b0;
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd, input logic clr);
        int  r;
        int  w;
        sb_t e;
        step();
        bram_in_ena   = 1'b1;
        bram_in_we    = we;
        bram_in_addr  = a;
        bram_in_wdata = wd;
        err_clr       = clr;
        r = int'(a[14:12]);
        w = int'(a[5:2]);
        if (we == 4'h0) begin
            e.due  = cyc + 2;
            e.data = (r >= NP) ? ERR : shadow[r][w];
            e.tag  = $sformatf("rd_%h", a);
            sbq.push_back(e);
        end else if (r < NP) begin
            for (int b = 0; b < 4; b++)
                if (we[b]) shadow[r][w][b*8 +: 8] = wd[b*8 +: 8];
        end
    endtask

    task automatic check_stats(input string tag, input int port, input int cnt);
        int exp_cnt;
        for (int k = 0; k < NP; k++) begin
`ifdef BRAM_PORT_DEMUX_STATS_EN
            exp_cnt = (k == port) ? cnt : 0;
`else
            exp_cnt = 0;
`endif
            check($sformatf("%s_%0d", tag, k), 64'(stat_wr_cnt[k*16 +: 16]), 64'(exp_cnt));
        end
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0;
        rst_n = 1'b0; bram_in_rst = 1'b0; bram_in_ena = 1'b0; bram_in_we = '0;
        bram_in_addr = '0; bram_in_wdata = '0; err_clr = 1'b0;

        idle(2);
        check("rst_sticky", 64'(err_sticky), 64'(0));
        check("rst_addr",   64'(err_addr),   64'(0));
        check("rst_count",  64'(err_count),  64'(0));
        check_stats("rst_stat", 0, 0);
        rst_n = 1'b1;
        bram_in_rst = 1'b1;
        #1;
        check("rst_bcast", 64'(bram_out_rst), 64'(5'h1f));
        bram_in_rst = 1'b0;
        idle(1);

        // Write two regions, read back-to-back and alternating
        access(32'h0000, 4'hF, 32'h11111111, 1'b0);
        access(32'h1000, 4'hF, 32'h22222222, 1'b0);
        #1 check("ena_wr_p1", 64'(bram_out_ena), 64'(5'b00010));
        access(32'h0000, 4'h0, 32'h0, 1'b0);
        access(32'h1000, 4'h0, 32'h0, 1'b0);
        access(32'h0000, 4'h0, 32'h0, 1'b0);
        access(32'h1000, 4'h0, 32'h0, 1'b0);
        access(32'h3004, 4'hF, 32'hCAFEBABE, 1'b0);
        access(32'h3004, 4'b0011, 32'h00001234, 1'b0);
        access(32'h4008, 4'hF, 32'h44444444, 1'b0);
        #1 check("ena_wr_p4", 64'(bram_out_ena), 64'(5'b10000));
        access(32'h3004, 4'h0, 32'h0, 1'b0);
        access(32'h4008, 4'h0, 32'h0, 1'b0);
        access(32'h0001_1000, 4'h0, 32'h0, 1'b0);
        access(32'h3004, 4'h0, 32'h0, 1'b0);
        idle(4);
        check("alias_no_err", 64'(err_sticky), 64'(0));

        // Stats: clear, 3 writes + 1 read to port 2
        access(32'h2000, 4'h0, 32'h0, 1'b1);
        idle(1);
        check_stats("clr_stat", 0, 0);
        access(32'h2000, 4'hF, 32'h20202020, 1'b0);
        access(32'h2004, 4'hF, 32'h21212121, 1'b0);
        access(32'h2008, 4'hF, 32'h23232323, 1'b0);
        access(32'h2004, 4'h0, 32'h0, 1'b0);
        #1 check("ena_rd_p2", 64'(bram_out_ena), 64'(5'b00100));
        idle(3);
        check_stats("stat", 2, 3);

        // Out-of-range logging
        access(32'h5000, 4'h0, 32'h0, 1'b0);
        #1 check("oor_ena", 64'(bram_out_ena), 64'(0));
        idle(1);
        check("err1_sticky", 64'(err_sticky), 64'(1));
        check("err1_addr",   64'(err_addr),   64'(32'h5000));
        check("err1_count",  64'(err_count),  64'(1));
        access(32'h7004, 4'hF, 32'hDEADBEEF, 1'b0);
        #1 check("oor_ena2", 64'(bram_out_ena), 64'(0));
        idle(1);
        check("err2_addr",  64'(err_addr),  64'(32'h5000));
        check("err2_count", 64'(err_count), 64'(2));
        access(32'h6000, 4'h0, 32'h0, 1'b1);
        idle(1);
        check("errclr_sticky", 64'(err_sticky), 64'(1));
        check("errclr_addr",   64'(err_addr),   64'(32'h6000));
        check("errclr_count",  64'(err_count),  64'(1));
        access(32'h0000, 4'h0, 32'h0, 1'b1);
        idle(1);
        check("clr_sticky", 64'(err_sticky), 64'(0));
        check("clr_addr",   64'(err_addr),   64'(0));
        check("clr_count",  64'(err_count),  64'(0));

        // Saturation
        for (int i = 0; i < 65536; i++) access(32'h5000, 4'hF, 32'(i), 1'b0);
        idle(1);
        check("sat_count", 64'(err_count), 64'(16'hFFFF));
        access(32'h7000, 4'h0, 32'h0, 1'b0);
        idle(3);
        check("sat_hold",  64'(err_count), 64'(16'hFFFF));
        check("sat_addr",  64'(err_addr),  64'(32'h5000));
        check("sb_drain",  64'(sbq.size()), 64'(0));

        // Reset with a read in flight: mux falls back to port 0
        access(32'h0000, 4'h0, 32'h0, 1'b0);
        idle(3);
        access(32'h5000, 4'h0, 32'h0, 1'b0);
        idle(3);
        access(32'h1000, 4'h0, 32'h0, 1'b0);
        step();
        bram_in_ena = 1'b0;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("mrst_sticky", 64'(err_sticky), 64'(0));
        check("mrst_addr",   64'(err_addr),   64'(0));
        check("mrst_count",  64'(err_count),  64'(0));
        check("mrst_rdata",  64'(bram_in_rdata), 64'(32'h11111111));
        check_stats("mrst_stat", 0, 0);
        step();
        check("mrst_rdata2", 64'(bram_in_rdata), 64'(32'h11111111));
        rst_n = 1'b1;
        idle(3);
        check("post_rst_rdata", 64'(bram_in_rdata), 64'(32'h11111111));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bram_port_demux_n.md
# bram_port_demux_n

Parametrised BRAM port demultiplexer: splits one AXI BRAM controller port into N_PORTS equal-sized BRAM ports selected by address bits, as used in front of the palette LUT memories. Read data is returned through a select pipeline matched to the downstream BRAM read latency, so back-to-back reads to different regions return the correct word. Out-of-range accesses return a fixed error word and are logged in sticky status registers readable by firmware.

## Interface
- N_PORTS, 5, number of downstream BRAM ports (1..16)
- REGION_AW, 12, log2 bytes per region; region index = addr[REGION_AW+SEL_W-1:REGION_AW]
- DATA_W, 32, data width (multiple of 8)
- ADDR_W, 32, address width
- READ_LATENCY, 1, downstream BRAM read latency in cycles (1..3)
- ERR_WORD, 32'hABADC0DE, read data for out-of-range region
- SEL_W (localparam), max(1, clog2(N_PORTS))

Ports:
- bram_in_clk  in  1  single clock; driven to every bram_out_clk
- bram_in_rst_n  in  1  asynchronous active-low reset of demux state
- bram_in_rst  in  1  BRAM port RST, passed to every bram_out_rst (not a demux reset)
- bram_in_ena  in  1  access enable
- bram_in_we  in  DATA_W/8  byte write enables
- bram_in_addr  in  ADDR_W  byte address
- bram_in_wdata  in  DATA_W  write data
- bram_in_rdata  out  DATA_W  read data
- bram_out_clk, bram_out_rst  out  N_PORTS  per-port clock / RST
- bram_out_ena  out  N_PORTS  per-port enable
- bram_out_we  out  N_PORTS*DATA_W/8  flattened, port k at slice k
- bram_out_addr  out  N_PORTS*ADDR_W  flattened
- bram_out_wdata  out  N_PORTS*DATA_W  flattened
- bram_out_rdata  in  N_PORTS*DATA_W  flattened
- err_clr  in  1  synchronous clear of error status
- err_sticky  out  1  out-of-range access seen
- err_addr  out  ADDR_W  address of first out-of-range access since clear
- err_count  out  16  out-of-range access count, saturating at 16'hFFFF
- stat_wr_cnt  out  N_PORTS*16  per-port write counters (see Configuration)

## Operation
- we/addr/wdata/rst/clk broadcast combinationally to all ports.
- bram_out_ena[k] = bram_in_ena & (idx == k); all zero when idx >= N_PORTS.
- Select pipeline: READ_LATENCY stages of {valid, oor, idx}, shifting every cycle; stage 0 loads {ena, idx>=N_PORTS, idx}.
- Output stage: if last stage valid, use its oor/idx and copy them into held register; otherwise use held register.
- rdata = ERR_WORD if oor, else bram_out_rdata slice idx. Held register resets to {oor=0, idx=0}.
- Error logging on any access (read or write) with ena=1 and idx >= N_PORTS, registered next edge: err_sticky=1; err_addr captured only when err_sticky was 0; err_count increments, saturating.
- err_clr: clears sticky, err_addr, err_count. Simultaneous error and clear: error wins as first event (sticky=1, err_addr=new, count=1).
- Upper address bits above the index field are ignored (aliasing permitted, not an error).

## Timing
- Reset (async assert, sync deassert assumed upstream): pipeline valid bits 0, held register 0, err_sticky 0, err_addr 0, err_count 0, stat_wr_cnt 0.
- Enable/write path: zero latency, combinational.
- Read issued at cycle t (ena=1) -> bram_in_rdata correct from cycle t+READ_LATENCY.
- Back-to-back reads to alternating regions: each returns its own region's data, one per cycle.
- Status outputs: one cycle after the triggering access.
- Reset mid-operation: pipeline flushed, in-flight reads return port 0 data.

## Configuration
- BRAM_PORT_DEMUX_STATS_EN defined: stat_wr_cnt[k] increments on each cycle with bram_out_ena[k]=1 and any we bit set; 16-bit saturating; cleared by reset and by err_clr.
- Not defined: counter logic absent, stat_wr_cnt tied to 0.

## Structure
- Package bram_demux_pkg: ERR_WORD default, status counter width (16), clog2 helper, sel-stage struct {valid, oor, idx}.
- Sub-module bram_demux_sel_pipe: READ_LATENCY-deep select delay line with held output register.

## Test plan
- Write 0x11111111 to 0x0000 and 0x22222222 to 0x1000, read both back-to-back, READ_LATENCY=2 -> rdata 0x11111111 at t+2, 0x22222222 at t+3.
- Read 0x5000 with N_PORTS=5 -> no bram_out_ena, rdata 0xABADC0DE, err_sticky=1, err_addr=0x5000, err_count=1.
- Second error at 0x7004 -> err_addr stays 0x5000, err_count=2; err_clr same cycle as error at 0x6000 -> sticky=1, err_addr=0x6000, count=1.
- Force err_count to 0xFFFF via 65536 errors -> stays 0xFFFF.
- Stats build: 3 writes to port 2, 1 read -> stat_wr_cnt[2]=3, others 0; non-stats build -> all 0.
- Assert bram_in_rst_n low with read in flight -> all status 0, rdata selects port 0.
